hex8_run_ctrl: RTL

HEX8_RUN_CTRL -- requirements
Module: hex8_run_ctrl

---
 rtl/hex8_run_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/hex8_run_ctrl.sv
// hex8_run_ctrl: debounced run/halt/single-step controller issuing CPU clock-enable pulses
module hex8_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int BASE_DIV = 1200,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_step,
  input  logic [2:0]  rate_sel,
  input  logic [7:0]  pc,
  input  logic [7:0]  bp_addr,
  input  logic        bp_en,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [15:0] step_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(BASE_DIV * 128 + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {HOLD = 2'b00, HALT = 2'b01, RUN = 2'b10, STEP = 2'b11} st_t;
  st_t st, st_n;
  logic [1:0] btn, s1, s2, db, armed, press, live;
  logic [DW-1:0] cnt [2];
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pre, pre_n, term;
  logic bp_hit_n, bp_live, bp_live_n;
  assign btn = {btn_step, btn_mode};
  assign term = (PW'(BASE_DIV) << rate_sel) - PW'(1);
  assign state = st;
  assign cpu_reset = (st == HOLD);
  // A button only arms once it has been seen released after reset, so a hold through reset is silent
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      live <= '0;
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      armed <= '0;
      press <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      live <= {live[0], 1'b1};
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        armed[i] <= armed[i] | (live[1] & ~s2[i]);
        press[i] <= 1'b0;
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          db[i] <= s2[i];
          press[i] <= s2[i] & armed[i];
        end else cnt[i] <= cnt[i] + DW'(1);
      end
    end
  always_comb begin
    st_n = st;
    pre_n = pre;
    bp_hit_n = bp_hit;
    bp_live_n = bp_live;
    cpu_en = 1'b0;
    case (st)
      HOLD: st_n = (hold_cnt == HW'(HOLD_CYCLES - 1)) ? HALT : HOLD;
      HALT:
        if (press[0]) begin
          st_n = RUN;
          pre_n = '0;
          bp_hit_n = 1'b0;
          bp_live_n = 1'b0;
        end else if (press[1]) st_n = STEP;
      RUN:
        if (press[0]) st_n = HALT;
        else if (pre >= term) begin
          cpu_en = 1'b1;
          pre_n = '0;
          bp_live_n = 1'b1;
        end else if (bp_live && bp_en && pc == bp_addr) begin
          st_n = HALT;
          bp_hit_n = 1'b1;
        end else pre_n = pre + PW'(1);
      STEP: begin
        cpu_en = 1'b1;
        st_n = HALT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= HOLD;
      hold_cnt <= '0;
      pre <= '0;
      bp_hit <= 1'b0;
      bp_live <= 1'b0;
      step_count <= '0;
    end else begin
      st <= st_n;
      hold_cnt <= (st == HOLD) ? hold_cnt + HW'(1) : '0;
      pre <= pre_n;
      bp_hit <= bp_hit_n;
      bp_live <= bp_live_n;
      step_count <= cpu_en ? step_count + 16'd1 : step_count;
    end
endmodule
